// File: rtl/word_scroll_scheduler.sv
// word_scroll_scheduler
// Conditions the Next/Prev buttons and the auto-play switch, then decides when
// to pulse nextWord/prevWord for the sentence display controller. In auto mode
// a dwell timer advances one word per DWELL_CYCLES, either stopping on the
// last word or wrapping when loop is set.
module word_scroll_scheduler #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DWELL_CYCLES    = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnNext,
  input  logic       btnPrev,
  input  logic       autoMode,
  input  logic       loop,
  input  logic [2:0] wordIndex,
  output logic       nextWord,
  output logic       prevWord,
  output logic       autoActive,
  output logic       autoDone
);

  localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int DW_W = ($clog2(DWELL_CYCLES) < 1) ? 1 : $clog2(DWELL_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {MANUAL, AUTO, DONE} state_t;

  // bit 0 = Next, bit 1 = Prev, bit 2 = auto-play switch
  logic [2:0] raw_in;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  // Fills with ones after reset; sync2_reg only reflects the pins once vld_reg[1] is set
  logic [1:0] vld_reg;
  logic [1:0] press;

  state_t          state_reg;
  logic [DW_W-1:0] dwell_cnt_reg;
  logic            hold_next_reg;
  logic            hold_prev_reg;
  logic            hold_exp_reg;

  logic new_next, new_prev;
  logic want_next_raw, want_prev_raw;
  logic want_next, want_prev, want_exp;
  logic manual_req, dwell_hit, blocked, auto_on;

  assign raw_in  = {autoMode, btnPrev, btnNext};
  assign auto_on = sync2_reg[2];

  // Two-flop synchronizers for all three asynchronous inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      vld_reg   <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
      vld_reg   <= {vld_reg[0], 1'b1};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [DB_W-1:0] cnt_reg;
      logic            level_reg;
      logic            prev_reg;
      // A button seen pressed straight out of reset stays disarmed until it is seen released
      logic            armed_reg;

      // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          prev_reg  <= 1'b0;
          armed_reg <= 1'b0;
        end else begin
          prev_reg <= level_reg;
          if (vld_reg[1] && !sync2_reg[gi]) begin
            armed_reg <= 1'b1;
          end
          if (sync2_reg[gi] == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            level_reg <= sync2_reg[gi];
            cnt_reg   <= '0;
          end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = level_reg & ~prev_reg & armed_reg;
    end
  endgenerate

  // Arbitrate fresh presses, held requests and dwell expiry for this cycle
  always_comb begin
    new_next      = press[0] & ~press[1];
    new_prev      = press[1] & ~press[0];
    want_next_raw = new_next | hold_next_reg;
    want_prev_raw = new_prev | hold_prev_reg;
    want_next     = want_next_raw & ~want_prev_raw;
    want_prev     = want_prev_raw & ~want_next_raw;
    manual_req    = want_next | want_prev;
    dwell_hit     = (state_reg == AUTO) && (dwell_cnt_reg == DW_LAST);
    want_exp      = (state_reg == AUTO) && (dwell_hit || hold_exp_reg);
    // The cycle right after a strobe is reserved so wordIndex can settle
    blocked       = nextWord | prevWord;
  end

  // Mode FSM with registered strobes, status flags, dwell timer and hold slots
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= MANUAL;
      nextWord      <= 1'b0;
      prevWord      <= 1'b0;
      autoActive    <= 1'b0;
      autoDone      <= 1'b0;
      dwell_cnt_reg <= '0;
      hold_next_reg <= 1'b0;
      hold_prev_reg <= 1'b0;
      hold_exp_reg  <= 1'b0;
    end else begin
      nextWord <= 1'b0;
      prevWord <= 1'b0;
      if (blocked) begin
        hold_next_reg <= want_next;
        hold_prev_reg <= want_prev;
        hold_exp_reg  <= want_exp;
      end else begin
        hold_next_reg <= 1'b0;
        hold_prev_reg <= 1'b0;
        hold_exp_reg  <= 1'b0;
      end

      unique case (state_reg)
        MANUAL: begin
          if (!blocked) begin
            nextWord <= want_next;
            prevWord <= want_prev;
          end
          if (auto_on) begin
            state_reg     <= AUTO;
            autoActive    <= 1'b1;
            dwell_cnt_reg <= '0;
          end
        end
        AUTO: begin
          if (dwell_hit) begin
            dwell_cnt_reg <= '0;
          end else if (dwell_cnt_reg != '1) begin
            dwell_cnt_reg <= dwell_cnt_reg + 1'b1;
          end
          if (!blocked) begin
            if (manual_req) begin
              // A manual press overrides a simultaneous expiry and restarts the dwell
              nextWord      <= want_next;
              prevWord      <= want_prev;
              dwell_cnt_reg <= '0;
            end else if (want_exp) begin
              if ((wordIndex != 3'd7) || loop) begin
                nextWord <= 1'b1;
              end else begin
                state_reg  <= DONE;
                autoActive <= 1'b0;
                autoDone   <= 1'b1;
              end
            end
          end
          if (!auto_on) begin
            state_reg    <= MANUAL;
            autoActive   <= 1'b0;
            autoDone     <= 1'b0;
            hold_exp_reg <= 1'b0;
          end
        end
        DONE: begin
          if (!blocked && manual_req) begin
            nextWord      <= want_next;
            prevWord      <= want_prev;
            dwell_cnt_reg <= '0;
            state_reg     <= AUTO;
            autoActive    <= 1'b1;
            autoDone      <= 1'b0;
          end
          if (!auto_on) begin
            state_reg  <= MANUAL;
            autoActive <= 1'b0;
            autoDone   <= 1'b0;
          end
        end
        default: begin
          state_reg  <= MANUAL;
          autoActive <= 1'b0;
          autoDone   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_scroll_scheduler.sv
// Directed bench for word_scroll_scheduler: expected strobes are queued as
// stimulus is driven and matched (kind and cycle) whenever the DUT strobes.
module tb_word_scroll_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnNext, btnPrev, autoMode, loop;
  logic [2:0] wordIndex;
  logic       nextWord, prevWord, autoActive, autoDone;

  typedef struct {
    bit is_prev;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   last_strobe = 1'b0;

  // Display-controller model: index = base + number of net advances
  logic [2:0] base_idx = 3'd0;
  logic [2:0] delta = 3'd0;
  assign wordIndex = base_idx + delta;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (nextWord) delta <= delta + 3'd1;
    else if (prevWord) delta <= delta - 3'd1;
  end

  word_scroll_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .DWELL_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btnNext(btnNext),
    .btnPrev(btnPrev),
    .autoMode(autoMode),
    .loop(loop),
    .wordIndex(wordIndex),
    .nextWord(nextWord),
    .prevWord(prevWord),
    .autoActive(autoActive),
    .autoDone(autoDone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push_exp(input bit is_prev, input int at);
    exp_t e;
    e.is_prev = is_prev;
    e.cyc     = at;
    sb.push_back(e);
  endtask

  // Called on every falling edge: match any strobe against the scoreboard
  task automatic monitor();
    exp_t e;
    bit   strobe;
    strobe = nextWord | prevWord;
    if (strobe) begin
      chk("strobe_spacing", {31'd0, last_strobe}, 32'd0);
      chk("strobe_exclusive", {31'd0, nextWord & prevWord}, 32'd0);
      n_checks++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_strobe: observed next=%0b prev=%0b at cycle %0d, expected none", nextWord, prevWord, cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("strobe_kind_is_prev", {31'd0, prevWord}, {31'd0, e.is_prev});
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
    last_strobe = strobe;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic drain(input string tag);
    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_missing_strobe: observed %0d strobes outstanding, expected 0 (first due cycle %0d)", tag, sb.size(), sb[0].cyc);
      sb.delete();
    end
  endtask

  task automatic set_idx(input logic [2:0] v);
    base_idx = v - delta;
  endtask

  initial begin
    int t;
    int p;
    reset = 1'b1; btnNext = 1'b0; btnPrev = 1'b0; autoMode = 1'b0; loop = 1'b0;
    tick(3);
    chk("reset_nextWord", {31'd0, nextWord}, 32'd0);
    chk("reset_prevWord", {31'd0, prevWord}, 32'd0);
    chk("reset_autoActive", {31'd0, autoActive}, 32'd0);
    chk("reset_autoDone", {31'd0, autoDone}, 32'd0);
    reset = 1'b0;
    tick(5);

    // Clean Next pulse: one nextWord 7 cycles after the raw edge
    t = cyc;
    btnNext = 1'b1;
    push_exp(1'b0, t + 7);
    tick(8);
    btnNext = 1'b0;
    tick(15);
    drain("clean_next");

    // Bouncing Prev: never stable for 4 cycles, no strobe
    for (int i = 0; i < 5; i++) begin
      btnPrev = 1'b1; tick(2);
      btnPrev = 1'b0; tick(2);
    end
    tick(15);
    drain("bounce_prev");

    // Simultaneous Next and Prev: both dropped
    btnNext = 1'b1; btnPrev = 1'b1;
    tick(12);
    btnNext = 1'b0; btnPrev = 1'b0;
    tick(15);
    drain("both_pressed");

    // Auto-play without loop from index 5
    set_idx(3'd5);
    loop = 1'b0;
    t = cyc;
    autoMode = 1'b1;
    push_exp(1'b0, t + 13);
    push_exp(1'b0, t + 23);
    wait_until(t + 2);
    chk("auto_not_yet_active", {31'd0, autoActive}, 32'd0);
    wait_until(t + 3);
    chk("auto_active_rise", {31'd0, autoActive}, 32'd1);
    wait_until(t + 32);
    chk("auto_not_yet_done", {31'd0, autoDone}, 32'd0);
    wait_until(t + 33);
    chk("auto_done", {31'd0, autoDone}, 32'd1);
    chk("auto_inactive_in_done", {31'd0, autoActive}, 32'd0);
    chk("index_at_last", {29'd0, wordIndex}, 32'd7);
    p = cyc;
    btnPrev = 1'b1;
    push_exp(1'b1, p + 7);
    push_exp(1'b0, p + 17);
    wait_until(p + 7);
    chk("done_prev_reactivates", {31'd0, autoActive}, 32'd1);
    chk("done_prev_clears_done", {31'd0, autoDone}, 32'd0);
    wait_until(p + 8);
    btnPrev = 1'b0;
    wait_until(p + 18);
    autoMode = 1'b0;
    wait_until(p + 22);
    chk("auto_off_manual", {31'd0, autoActive}, 32'd0);
    tick(15);
    drain("auto_noloop");

    // Auto-play with loop at the last word wraps to 0
    set_idx(3'd7);
    loop = 1'b1;
    t = cyc;
    autoMode = 1'b1;
    push_exp(1'b0, t + 13);
    wait_until(t + 14);
    chk("loop_wrap_index", {29'd0, wordIndex}, 32'd0);
    chk("loop_still_active", {31'd0, autoActive}, 32'd1);
    autoMode = 1'b0;
    tick(15);
    drain("auto_loop");
    loop = 1'b0;

    // Manual Next landing on dwell expiry, then reset mid-dwell with a held button
    set_idx(3'd2);
    t = cyc;
    autoMode = 1'b1;
    wait_until(t + 6);
    btnNext = 1'b1;
    push_exp(1'b0, t + 13);
    push_exp(1'b0, t + 23);
    wait_until(t + 14);
    btnNext = 1'b0;
    wait_until(t + 25);
    btnNext = 1'b1;
    wait_until(t + 27);
    reset = 1'b1;
    autoMode = 1'b0;
    wait_until(t + 28);
    chk("midreset_nextWord", {31'd0, nextWord}, 32'd0);
    chk("midreset_prevWord", {31'd0, prevWord}, 32'd0);
    chk("midreset_autoActive", {31'd0, autoActive}, 32'd0);
    chk("midreset_autoDone", {31'd0, autoDone}, 32'd0);
    wait_until(t + 30);
    reset = 1'b0;
    wait_until(t + 45);
    chk("post_reset_manual", {31'd0, autoActive}, 32'd0);
    drain("held_through_reset");
    btnNext = 1'b0;
    wait_until(t + 55);
    btnNext = 1'b1;
    push_exp(1'b0, t + 62);
    wait_until(t + 63);
    btnNext = 1'b0;
    tick(15);
    drain("repress_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/word_scroll_scheduler.md
# word_scroll_scheduler

Sequences the sentence display's word scrolling. Turns raw Next/Prev push-buttons and an auto-play switch into the single-cycle `nextWord`/`prevWord` strobes consumed by the sentence display controller. Uses the controller's `wordIndex` (0 = first word, 7 = last) as feedback. Sits between the board I/O and the display controller, on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles before a button level is accepted (10 ms at 100 MHz).
- `DWELL_CYCLES`, default 100_000_000: cycles each word stays on screen in auto mode (1 s).
- `clk`, input, 1: system clock; all logic on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `btnNext`, input, 1: raw asynchronous Next button, active-high.
- `btnPrev`, input, 1: raw asynchronous Prev button, active-high.
- `autoMode`, input, 1: raw asynchronous switch; 1 = auto-play.
- `loop`, input, 1: quasi-static; 1 = auto-play wraps from word 7 to word 0.
- `wordIndex`, input, 3: current word index from the display controller.
- `nextWord`, output, 1: one-cycle advance strobe.
- `prevWord`, output, 1: one-cycle retreat strobe.
- `autoActive`, output, 1: high in state AUTO.
- `autoDone`, output, 1: high in state DONE.

## Operation
- Input conditioning:
  - `btnNext`, `btnPrev` and `autoMode` each pass through a 2-flop synchronizer.
  - `btnNext` and `btnPrev` then pass through a per-button debouncer. The debounced level changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
  - A rising edge of a debounced button level is a press. There is no auto-repeat while a button is held.
  - `autoMode` is synchronized only, not debounced.
- Arbitration:
  - Both presses in the same cycle: both are dropped and no strobe is issued.
  - A manual press beats a dwell expiry in the same cycle.
- Strobe spacing:
  - `nextWord` and `prevWord` are never high together.
  - After any strobe, at least one idle cycle follows so that `wordIndex` has updated before the next decision.
  - A press or expiry that lands in the idle cycle is held and issued in the next cycle. The holding register is one entry per source.
- FSM states and transitions:
  - MANUAL:
    - Next press → `nextWord`; Prev press → `prevWord`.
    - Synchronized `autoMode`=1 → AUTO, with the dwell counter cleared.
  - AUTO:
    - The dwell counter increments every cycle.
    - At count `DWELL_CYCLES`-1 it clears. Then:
      - if `wordIndex`≠7, or `loop`=1: issue `nextWord`, and the controller wraps 7→0;
      - if `wordIndex`=7 and `loop`=0: no strobe, go to DONE.
    - A manual press issues its strobe and clears the dwell counter. The state stays AUTO.
    - `autoMode`=0 → MANUAL.
  - DONE:
    - No automatic strobes.
    - A Prev or Next press issues its strobe, clears the dwell counter and returns to AUTO.
    - `autoMode`=0 → MANUAL.
- Counter widths: `$clog2` of the respective parameter, minimum 1 bit. Counters saturate and never wrap.

## Timing
- Reset values:
  - state MANUAL;
  - `nextWord`, `prevWord`, `autoActive`, `autoDone` = 0;
  - synchronizers, debounced levels, counters and held requests = 0.
- Reset mid-operation: any held request or in-progress debounce is discarded. A button held through reset produces no press until it is released and pressed again.
- Latency from a raw button edge to the strobe: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 edge-detect/output register = `DEBOUNCE_CYCLES`+3 cycles. All outputs are registered.
- Auto dwell: consecutive auto `nextWord` strobes are exactly `DWELL_CYCLES` cycles apart (rising edge to rising edge), provided no manual press occurs. `DWELL_CYCLES` ≥ 2 is required.
- Entering AUTO: the first auto strobe is issued `DWELL_CYCLES` cycles after `autoActive` rises.
- `autoActive` and `autoDone` update in the cycle the state changes.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `DWELL_CYCLES`=10.
- Reset, clean `btnNext` pulse held for 8 cycles → exactly one `nextWord` pulse, 7 cycles after the raw edge; `prevWord` stays 0.
- `btnPrev` toggling every 2 cycles for 20 cycles, then steady low → no strobe.
- `btnNext` and `btnPrev` rising in the same cycle and held → no strobes.
- `autoMode`=1, `loop`=0, `wordIndex` model starting at 5 → `nextWord` at +10 and +20 cycles after `autoActive` rises. At +30, `autoDone`=1 and no strobe. A Prev press then gives `prevWord` and `autoActive`=1.
- AUTO with `loop`=1 at `wordIndex`=7 → `nextWord` at dwell expiry; the model index wraps to 0.
- AUTO with a Next press landing in the cycle of dwell expiry → one `nextWord` only; the next auto strobe follows 10 cycles later. `reset` asserted mid-dwell → outputs 0, state MANUAL.
